// File: rtl/alu_operand_stage.sv
// Execute-entry operand stage ahead of the ALU.
// Resolves rs1/rs2 through EX/MEM and MEM/WB forwarding, picks the immediate or
// register operand for y, normalises funct3/funct7 and the shift amount, and
// registers everything behind a valid/ready handshake with load-use stall and flush.
module alu_operand_stage #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,

  // Decode side
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [REG_AW-1:0] in_rs1_addr,
  input  logic [REG_AW-1:0] in_rs2_addr,
  input  logic [REG_AW-1:0] in_rd_addr,
  input  logic [XLEN-1:0]   in_rs1_data,
  input  logic [XLEN-1:0]   in_rs2_data,
  input  logic [XLEN-1:0]   in_imm,
  input  logic              in_use_imm,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,

  // EX/MEM forwarding source
  input  logic              exmem_we,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic [XLEN-1:0]   exmem_data,
  input  logic              exmem_is_load,

  // MEM/WB forwarding source
  input  logic              memwb_we,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic [XLEN-1:0]   memwb_data,

  // ALU side
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   alu_x,
  output logic [XLEN-1:0]   alu_y,
  output logic [3:0]        alu_funct3,
  output logic [6:0]        alu_funct7,
  output logic [REG_AW-1:0] out_rd,
  output logic [XLEN-1:0]   out_rs2_data
);

  localparam logic [2:0] Funct3Sll = 3'b001;
  localparam logic [2:0] Funct3Sr  = 3'b101;

  // Combinational operand resolution
  logic [XLEN-1:0] rs1_fwd;
  logic [XLEN-1:0] rs2_fwd;
  logic [XLEN-1:0] y_sel;
  logic [XLEN-1:0] y_norm;
  logic [6:0]      funct7_norm;
  logic            is_shift;
  logic            rs1_load_hit;
  logic            rs2_load_hit;
  logic            stall;
  logic            accept;

  // Registered outputs
  logic              valid_q,    valid_d;
  logic [XLEN-1:0]   x_q,        x_d;
  logic [XLEN-1:0]   y_q,        y_d;
  logic [3:0]        funct3_q,   funct3_d;
  logic [6:0]        funct7_q,   funct7_d;
  logic [REG_AW-1:0] rd_q,       rd_d;
  logic [XLEN-1:0]   rs2_data_q, rs2_data_d;

  // rs1 forwarding: x0 reads as zero, EX/MEM beats MEM/WB, else register file.
  // A nonzero address can only match a nonzero rd, so x0 writers are ignored.
  always_comb begin
    rs1_fwd = in_rs1_data;
    if (in_rs1_addr == '0) begin
      rs1_fwd = '0;
    end else if (exmem_we && (exmem_rd == in_rs1_addr)) begin
      rs1_fwd = exmem_data;
    end else if (memwb_we && (memwb_rd == in_rs1_addr)) begin
      rs1_fwd = memwb_data;
    end
  end

  // rs2 forwarding, same priority as rs1; also feeds the store-data output.
  always_comb begin
    rs2_fwd = in_rs2_data;
    if (in_rs2_addr == '0) begin
      rs2_fwd = '0;
    end else if (exmem_we && (exmem_rd == in_rs2_addr)) begin
      rs2_fwd = exmem_data;
    end else if (memwb_we && (memwb_rd == in_rs2_addr)) begin
      rs2_fwd = memwb_data;
    end
  end

  // Load-use hazard: a load in EX/MEM has no data yet, so a dependent
  // instruction must wait. rs2 only matters when it is actually read (R-type).
  always_comb begin
    rs1_load_hit = (exmem_rd == in_rs1_addr);
    rs2_load_hit = !in_use_imm && (exmem_rd == in_rs2_addr);
    stall        = in_valid && exmem_we && exmem_is_load && (exmem_rd != '0) &&
                   (rs1_load_hit || rs2_load_hit);
  end

  // Operand y selection and field normalisation.
  always_comb begin
    is_shift = (in_funct3 == Funct3Sll) || (in_funct3 == Funct3Sr);
    y_sel    = in_use_imm ? in_imm : rs2_fwd;
    y_norm   = y_sel;
    // Shift amount lives in the low five bits; the I-type encoding also puts
    // funct7 into imm[11:5], which must not leak into the amount.
    if (is_shift) begin
      y_norm = {{(XLEN-5){1'b0}}, y_sel[4:0]};
    end
    // Immediate ops carry imm bits where funct7 would be; only SRAI/SRLI
    // use them as funct7, so ADDI with imm[10]=1 never turns into SUB.
    funct7_norm = 7'b0;
    if (!in_use_imm || (in_funct3 == Funct3Sr)) begin
      funct7_norm = in_funct7;
    end
  end

  // Handshake: flush and stall both block acceptance; the output slot is
  // free when empty or when it is being drained this cycle.
  always_comb begin
    in_ready = !stall && !flush && (!valid_q || out_ready);
    accept   = in_valid && in_ready;
  end

  // Next-state: flush kills the held instruction, a transfer loads a new one,
  // a drain without a transfer leaves a bubble, otherwise hold bit-for-bit.
  always_comb begin
    valid_d    = valid_q;
    x_d        = x_q;
    y_d        = y_q;
    funct3_d   = funct3_q;
    funct7_d   = funct7_q;
    rd_d       = rd_q;
    rs2_data_d = rs2_data_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d    = 1'b1;
      x_d        = rs1_fwd;
      y_d        = y_norm;
      funct3_d   = {1'b0, in_funct3};
      funct7_d   = funct7_norm;
      rd_d       = in_rd_addr;
      rs2_data_d = rs2_fwd;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  // Pipeline register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      funct3_q   <= '0;
      funct7_q   <= '0;
      rd_q       <= '0;
      rs2_data_q <= '0;
    end else begin
      valid_q    <= valid_d;
      x_q        <= x_d;
      y_q        <= y_d;
      funct3_q   <= funct3_d;
      funct7_q   <= funct7_d;
      rd_q       <= rd_d;
      rs2_data_q <= rs2_data_d;
    end
  end

  assign out_valid    = valid_q;
  assign alu_x        = x_q;
  assign alu_y        = y_q;
  assign alu_funct3   = funct3_q;
  assign alu_funct7   = funct7_q;
  assign out_rd       = rd_q;
  assign out_rs2_data = rs2_data_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage with a scoreboard of expected outputs.
module tb_alu_operand_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rs1_addr, in_rs2_addr, in_rd_addr;
  logic [31:0] in_rs1_data, in_rs2_data, in_imm;
  logic        in_use_imm;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic        exmem_we;
  logic [4:0]  exmem_rd;
  logic [31:0] exmem_data;
  logic        exmem_is_load;
  logic        memwb_we;
  logic [4:0]  memwb_rd;
  logic [31:0] memwb_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] alu_x, alu_y;
  logic [3:0]  alu_funct3;
  logic [6:0]  alu_funct7;
  logic [4:0]  out_rd;
  logic [31:0] out_rs2_data;

  typedef struct packed {
    logic [31:0] x;
    logic [31:0] y;
    logic [3:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd;
    logic [31:0] rs2;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  alu_operand_stage #(.XLEN(32), .REG_AW(5)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_rs1_addr  (in_rs1_addr),
    .in_rs2_addr  (in_rs2_addr),
    .in_rd_addr   (in_rd_addr),
    .in_rs1_data  (in_rs1_data),
    .in_rs2_data  (in_rs2_data),
    .in_imm       (in_imm),
    .in_use_imm   (in_use_imm),
    .in_funct3    (in_funct3),
    .in_funct7    (in_funct7),
    .exmem_we     (exmem_we),
    .exmem_rd     (exmem_rd),
    .exmem_data   (exmem_data),
    .exmem_is_load(exmem_is_load),
    .memwb_we     (memwb_we),
    .memwb_rd     (memwb_rd),
    .memwb_data   (memwb_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .alu_x        (alu_x),
    .alu_y        (alu_y),
    .alu_funct3   (alu_funct3),
    .alu_funct7   (alu_funct7),
    .out_rd       (out_rd),
    .out_rs2_data (out_rs2_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] d,
                           input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] im,
                           input logic ui, input logic [2:0] f3, input logic [6:0] f7);
    in_valid    = 1'b1;
    in_rs1_addr = a1;
    in_rs2_addr = a2;
    in_rd_addr  = d;
    in_rs1_data = d1;
    in_rs2_data = d2;
    in_imm      = im;
    in_use_imm  = ui;
    in_funct3   = f3;
    in_funct7   = f7;
  endtask

  task automatic set_fwd(input logic ew, input logic [4:0] er, input logic [31:0] ed,
                         input logic el, input logic mw, input logic [4:0] mr,
                         input logic [31:0] md);
    exmem_we      = ew;
    exmem_rd      = er;
    exmem_data    = ed;
    exmem_is_load = el;
    memwb_we      = mw;
    memwb_rd      = mr;
    memwb_data    = md;
  endtask

  task automatic push(input logic [31:0] x, input logic [31:0] y, input logic [3:0] f3,
                      input logic [6:0] f7, input logic [4:0] rd, input logic [31:0] rs2);
    exp_t e;
    e.x = x; e.y = y; e.f3 = f3; e.f7 = f7; e.rd = rd; e.rs2 = rs2;
    exp_q.push_back(e);
  endtask

  // Scoreboard: every output handshake must match the oldest expectation.
  always @(negedge clk) begin
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      vectors++;
      assert (exp_q.size() != 0) else begin
        miscompares++;
        $error("FAIL sb_unexpected: observed output x=%h with no expectation queued", alu_x);
      end
      if (exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb_x",   alu_x,                 e.x);
        check("sb_y",   alu_y,                 e.y);
        check("sb_f3",  {28'b0, alu_funct3},   {28'b0, e.f3});
        check("sb_f7",  {25'b0, alu_funct7},   {25'b0, e.f7});
        check("sb_rd",  {27'b0, out_rd},       {27'b0, e.rd});
        check("sb_rs2", out_rs2_data,          e.rs2);
      end
    end
  end

  initial begin
    exp_t dropped;
    rst = 1'b1;
    flush = 1'b0;
    out_ready = 1'b1;
    set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
    set_instr(5'd1, 5'd2, 5'd3, 32'hAAAA, 32'hBBBB, 32'h7, 1'b0, 3'b000, 7'h00);

    // Reset with a valid instruction presented
    tick();
    check("rst_valid", {31'b0, out_valid}, 32'h0);
    check("rst_x", alu_x, 32'h0);
    check("rst_y", alu_y, 32'h0);
    check("rst_f3", {28'b0, alu_funct3}, 32'h0);
    check("rst_f7", {25'b0, alu_funct7}, 32'h0);
    check("rst_rd", {27'b0, out_rd}, 32'h0);
    check("rst_rs2", out_rs2_data, 32'h0);
    tick();
    check("rst_valid2", {31'b0, out_valid}, 32'h0);
    rst = 1'b0;
    in_valid = 1'b0;
    tick();
    check("rst_nothing_taken", {31'b0, out_valid}, 32'h0);

    // Forwarding priority, back-to-back transfers
    set_fwd(1'b1, 5'd5, 32'h11, 1'b0, 1'b1, 5'd5, 32'h22);
    set_instr(5'd5, 5'd6, 5'd9, 32'h33, 32'h44, 32'h0, 1'b0, 3'b000, 7'h00);
    #1 check("fwd_ready", {31'b0, in_ready}, 32'h1);
    push(32'h11, 32'h44, 4'h0, 7'h00, 5'd9, 32'h44);
    tick();
    check("fwd_valid", {31'b0, out_valid}, 32'h1);
    exmem_we = 1'b0;
    #1 check("fwd_ready2", {31'b0, in_ready}, 32'h1);
    push(32'h22, 32'h44, 4'h0, 7'h00, 5'd9, 32'h44);
    tick();
    set_fwd(1'b1, 5'd0, 32'h11, 1'b0, 1'b1, 5'd0, 32'h22);
    in_rs1_addr = 5'd0;
    push(32'h0, 32'h44, 4'h0, 7'h00, 5'd9, 32'h44);
    tick();
    // EX/MEM writing x0 is ignored; rs2 comes from MEM/WB, R-type keeps funct7
    set_fwd(1'b1, 5'd0, 32'h11, 1'b0, 1'b1, 5'd6, 32'h66);
    set_instr(5'd5, 5'd6, 5'd10, 32'h33, 32'h44, 32'h0, 1'b0, 3'b000, 7'h20);
    push(32'h33, 32'h66, 4'h0, 7'h20, 5'd10, 32'h66);
    tick();
    in_valid = 1'b0;
    tick();
    check("drain_bubble", {31'b0, out_valid}, 32'h0);

    // Load-use stall while draining
    set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
    set_instr(5'd2, 5'd0, 5'd4, 32'h5, 32'hDEAD, 32'h3, 1'b1, 3'b000, 7'h00);
    push(32'h5, 32'h3, 4'h0, 7'h00, 5'd4, 32'h0);
    tick();
    set_fwd(1'b1, 5'd7, 32'h77, 1'b1, 1'b0, 5'd0, 32'h0);
    set_instr(5'd1, 5'd7, 5'd3, 32'h10, 32'h99, 32'h0, 1'b0, 3'b000, 7'h00);
    #1 check("lu_stall_ready", {31'b0, in_ready}, 32'h0);
    tick();
    check("lu_bubble", {31'b0, out_valid}, 32'h0);
    exmem_is_load = 1'b0;
    #1 check("lu_release_ready", {31'b0, in_ready}, 32'h1);
    push(32'h10, 32'h77, 4'h0, 7'h00, 5'd3, 32'h77);
    tick();
    check("lu_accepted", {31'b0, out_valid}, 32'h1);
    in_valid = 1'b0;
    set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
    tick();

    // Backpressure: hold for 3 cycles
    set_instr(5'd1, 5'd2, 5'd5, 32'hA, 32'hB, 32'h0, 1'b0, 3'b110, 7'h00);
    push(32'hA, 32'hB, 4'h6, 7'h00, 5'd5, 32'hB);
    tick();
    out_ready = 1'b0;
    set_instr(5'd3, 5'd0, 5'd6, 32'hC, 32'h0, 32'h10, 1'b1, 3'b100, 7'h00);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_ready", {31'b0, in_ready}, 32'h0);
      check("bp_valid", {31'b0, out_valid}, 32'h1);
      check("bp_x", alu_x, 32'hA);
      check("bp_y", alu_y, 32'hB);
      tick();
    end
    out_ready = 1'b1;
    #1 check("bp_release_ready", {31'b0, in_ready}, 32'h1);
    push(32'hC, 32'h10, 4'h4, 7'h00, 5'd6, 32'h0);
    tick();
    check("bp_next_valid", {31'b0, out_valid}, 32'h1);
    check("bp_next_x", alu_x, 32'hC);
    in_valid = 1'b0;
    tick();

    // Flush while holding with a new input pending
    set_instr(5'd1, 5'd0, 5'd8, 32'h1234, 32'h0, 32'h1, 1'b1, 3'b000, 7'h00);
    push(32'h1234, 32'h1, 4'h0, 7'h00, 5'd8, 32'h0);
    tick();
    out_ready = 1'b0;
    flush = 1'b1;
    set_instr(5'd1, 5'd0, 5'd9, 32'h5555, 32'h0, 32'h2, 1'b1, 3'b000, 7'h00);
    #1 check("fl_ready", {31'b0, in_ready}, 32'h0);
    tick();
    flush = 1'b0;
    check("fl_valid", {31'b0, out_valid}, 32'h0);
    dropped = exp_q.pop_front();
    out_ready = 1'b1;
    #1 check("fl_pending_ready", {31'b0, in_ready}, 32'h1);
    push(32'h5555, 32'h2, 4'h0, 7'h00, 5'd9, 32'h0);
    tick();
    check("fl_b_loaded", alu_x, 32'h5555);
    in_valid = 1'b0;
    tick();

    // Reset while holding loses the instruction
    set_instr(5'd1, 5'd0, 5'd2, 32'hAB, 32'h0, 32'h0, 1'b1, 3'b000, 7'h00);
    push(32'hAB, 32'h0, 4'h0, 7'h00, 5'd2, 32'h0);
    tick();
    out_ready = 1'b0;
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rh_valid", {31'b0, out_valid}, 32'h0);
    check("rh_x", alu_x, 32'h0);
    check("rh_rd", {27'b0, out_rd}, 32'h0);
    dropped = exp_q.pop_front();
    out_ready = 1'b1;

    // Normalisation; load in EX/MEM matching rs2 of an I-type must not stall
    set_fwd(1'b1, 5'd3, 32'h1, 1'b1, 1'b0, 5'd0, 32'h0);
    set_instr(5'd1, 5'd3, 5'd1, 32'h0, 32'h0, 32'hFFFF_FFFF, 1'b1, 3'b000, 7'h20);
    #1 check("addi_no_stall", {31'b0, in_ready}, 32'h1);
    push(32'h0, 32'hFFFF_FFFF, 4'h0, 7'h00, 5'd1, 32'h1);
    tick();
    set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
    set_instr(5'd2, 5'd0, 5'd2, 32'h8000_0000, 32'h0, 32'h405, 1'b1, 3'b101, 7'h20);
    push(32'h8000_0000, 32'h5, 4'h5, 7'h20, 5'd2, 32'h0);
    tick();
    set_instr(5'd4, 5'd3, 5'd3, 32'h1, 32'h23, 32'h0, 1'b0, 3'b001, 7'h00);
    push(32'h1, 32'h3, 4'h1, 7'h00, 5'd3, 32'h23);
    tick();
    in_valid = 1'b0;
    tick();
    tick();

    check("sb_drained", exp_q.size(), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_operand_stage.md
# alu_operand_stage

Execute-entry pipeline stage directly upstream of the ALU. It accepts decoded instructions from the decode stage and resolves register operands through EX/MEM and MEM/WB forwarding. It selects immediate versus register operand and normalises `funct3`/`funct7`/shift amount. Its registered outputs drive the ALU `x`, `y`, `funct3` and `funct7` inputs, with a valid/ready handshake on both sides, load-use stall detection, and flush.

## Interface
Parameters:
- `XLEN`, 32, datapath width; the ALU is fixed at 32.
- `REG_AW`, 5, register address width.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `flush` in 1: discard the held and incoming instruction (branch/jump redirect).
- `in_valid` in 1: decode presents an instruction.
- `in_ready` out 1: stage accepts this cycle.
- `in_rs1_addr`, `in_rs2_addr`, `in_rd_addr` in `REG_AW`: register addresses.
- `in_rs1_data`, `in_rs2_data` in `XLEN`: register file read data.
- `in_imm` in `XLEN`: sign-extended immediate.
- `in_use_imm` in 1: 1 means I-type, so `y` comes from `in_imm`.
- `in_funct3` in 3, `in_funct7` in 7: instruction fields.
- `exmem_we` in 1, `exmem_rd` in `REG_AW`, `exmem_data` in `XLEN`, `exmem_is_load` in 1: EX/MEM forwarding source.
- `memwb_we` in 1, `memwb_rd` in `REG_AW`, `memwb_data` in `XLEN`: MEM/WB forwarding source.
- `out_valid` out 1: ALU operands valid.
- `out_ready` in 1: downstream (ALU/EX-MEM register) accepts.
- `alu_x`, `alu_y` out `XLEN`: ALU operands.
- `alu_funct3` out 4: bit 3 is always 0.
- `alu_funct7` out 7: normalised funct7.
- `out_rd` out `REG_AW`: destination register.
- `out_rs2_data` out `XLEN`: forwarded rs2, used as store data.

## Operation
Forwarding, evaluated combinationally per source operand (rs1, rs2):
- If the address is 0, the operand is 0 and is never forwarded.
- Else if `exmem_we` is set and `exmem_rd` matches the address, use `exmem_data`. EX/MEM has priority.
- Else if `memwb_we` is set and `memwb_rd` matches the address, use `memwb_data`.
- Else use the register file data.

Load-use stall:
- `stall` = `in_valid & exmem_we & exmem_is_load & exmem_rd != 0 & (exmem_rd == rs1_addr | (!in_use_imm & exmem_rd == rs2_addr))`.

Operand and field selection:
- `y` = `in_use_imm ? in_imm : fwd_rs2`.
- If `in_funct3` is `001` or `101` (shifts), `y` is masked to `y[4:0]` zero-extended.
- `alu_funct7` = `in_funct7` when `!in_use_imm` or `in_funct3 == 101`; otherwise 0. This ensures ADDI never becomes SUB.
- `alu_funct3` = `{1'b0, in_funct3}`.

Handshake:
- `in_ready` = `!stall & !flush & (!out_valid | out_ready)`.
- A transfer occurs when `in_valid & in_ready`. On transfer, all outputs load on the next edge and `out_valid` becomes 1.
- `out_valid & !out_ready` means the stage holds: outputs remain stable bit-for-bit and `in_ready` is 0.
- `out_valid & out_ready` with no new transfer clears `out_valid` to 0.

Flush:
- `flush` clears `out_valid` on the next edge, regardless of `out_ready`.
- The input is not accepted that cycle.
- Flush has priority over stall and over transfer.

## Timing
- Reset: `out_valid`=0, `alu_x`=0, `alu_y`=0, `alu_funct3`=0, `alu_funct7`=0, `out_rd`=0, `out_rs2_data`=0.
- `in_ready` is combinational and therefore 0 while `rst` is high is not required. Inputs are ignored during reset.
- Latency: 1 cycle from accepted input to `out_valid`.
- Throughput: 1 instruction per cycle when `out_ready` is held at 1.
- Forwarding values are sampled in the cycle of acceptance only. They are not re-evaluated while the stage is holding.
- Stall:
  - `in_ready` is 0 for every cycle in which the stall condition holds.
  - If the stage was draining, `out_valid` falls to 0, which acts as a bubble.
  - The instruction is accepted on the first cycle the condition clears.
- A stall and `out_valid & !out_ready` at the same time: hold, since both block acceptance.
- `rst` asserted mid-hold or mid-stall: the next edge forces reset values. The held instruction is lost.
- Both forwarding sources match the same register: EX/MEM wins. A source whose `rd` is x0 is ignored even with `we`=1.

## Test plan
- Reset:
  - Stimulus: assert `rst` for 2 cycles with `in_valid`=1.
  - Required response: all outputs 0, `out_valid`=0 after the first edge, and nothing accepted.
- Forward priority:
  - Stimulus: rs1=5, `exmem_rd`=5 with data 0x11, `memwb_rd`=5 with data 0x22, rf data 0x33.
  - Required response: `alu_x`=0x11. With `exmem_we`=0 instead, `alu_x`=0x22. With rs1=0 and both `rd`=0, `alu_x`=0.
- Load-use:
  - Stimulus: `exmem_is_load`=1, `exmem_rd`=7, incoming ADD with rs2=7, held for 1 cycle, then `exmem_is_load` drops.
  - Required response: `in_ready`=0 for 1 cycle, `out_valid` bubble, then accepted with the forwarded value.
- Backpressure:
  - Stimulus: `out_ready`=0 for 3 cycles after a transfer of x=0xA, y=0xB.
  - Required response: outputs stable, `in_ready`=0. After `out_ready`=1, the next instruction appears 1 cycle later.
- Flush:
  - Stimulus: flush while `out_valid`=1, `out_ready`=0 and `in_valid`=1.
  - Required response: next cycle `out_valid`=0, and the input is not consumed.
- Normalisation:
  - Stimulus 1: ADDI with `in_funct7`=0x20 and imm=-1.
    - Required response: `alu_funct7`=0, `alu_y`=0xFFFFFFFF.
  - Stimulus 2: SRAI with funct7=0x20 and imm=0x405.
    - Required response: funct7=0x20, `alu_y`=5.
  - Stimulus 3: SLL reg with rs2=0x23.
    - Required response: `alu_y`=3.
